// File: rtl/mac_feeder_if.sv
// mac_feeder_if: matrix-entry stream in, mac operand/eof stream out
interface mac_feeder_if #(
  parameter int RW = 10,
  parameter int CW = 10
);
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] in_row;
  logic [CW-1:0] in_col;
  logic [63:0]   in_val;
  logic          in_last;
  logic          mac_wr;
  logic [RW-1:0] mac_row;
  logic [63:0]   mac_v0;
  logic [63:0]   mac_v1;
  logic          mac_eof;
  modport master (
    output in_valid, in_row, in_col, in_val, in_last,
    input  in_ready, mac_wr, mac_row, mac_v0, mac_v1, mac_eof
  );
  modport slave (
    input  in_valid, in_row, in_col, in_val, in_last,
    output in_ready, mac_wr, mac_row, mac_v0, mac_v1, mac_eof
  );
endinterface

// File: rtl/mac_feeder.sv
// mac_feeder: pairs each matrix entry with x[col] from a local RAM and feeds the mac
module mac_feeder #(
  parameter int INTERMEDIATOR_DEPTH      = 1024,
  parameter int LOG2_INTERMEDIATOR_DEPTH = $clog2(INTERMEDIATOR_DEPTH),
  parameter int VECTOR_DEPTH             = 1024,
  parameter int LOG2_VECTOR_DEPTH        = $clog2(VECTOR_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         vec_wr,
  input  logic [LOG2_VECTOR_DEPTH-1:0] vec_addr,
  input  logic [63:0]                  vec_data,
  input  logic                         start,
  mac_feeder_if.slave                  m,
  output logic                         busy,
  output logic                         done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, EOF} state_t;
  state_t state, state_nx;
  logic accept;
  logic s1_v;
  logic [LOG2_INTERMEDIATOR_DEPTH-1:0] s1_row;
  logic [63:0] s1_val, rd;
  logic [63:0] ram [VECTOR_DEPTH];
  assign accept = m.in_valid & m.in_ready;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // s1_v clear means the beat now on the mac port is the final one, so eof lands right after it
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = start ? RUN : IDLE;
      RUN:   state_nx = (accept && m.in_last) ? DRAIN : RUN;
      DRAIN: state_nx = s1_v ? DRAIN : EOF;
      EOF:   state_nx = IDLE;
    endcase
  end
  always_comb begin
    m.in_ready = state == RUN;
    m.mac_eof  = state == EOF;
    done       = state == EOF;
    busy       = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (vec_wr && state == IDLE) ram[vec_addr] <= vec_data;
    rd <= ram[m.in_col];
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_row <= m.in_row;
      s1_val <= m.in_val;
    end
    if (rst) begin
      s1_v      <= 1'b0;
      m.mac_wr  <= 1'b0;
      m.mac_row <= '0;
      m.mac_v0  <= '0;
      m.mac_v1  <= '0;
    end else begin
      s1_v     <= accept;
      m.mac_wr <= s1_v;
      if (s1_v) begin
        m.mac_row <= s1_row;
        m.mac_v0  <= s1_val;
        m.mac_v1  <= rd;
      end
    end
  end
endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder: randomized scoreboard bench; model tracks x[], pass state and beat timing
module tb_mac_feeder;
  localparam int RW = 10;
  localparam int CW = 10;
  typedef struct {
    logic [RW-1:0] row;
    logic [63:0]   v0;
    logic [63:0]   v1;
    int            due;
  } beat_t;
  logic clk = 0;
  logic rst = 1;
  logic vec_wr = 0;
  logic start = 0;
  logic [CW-1:0] vec_addr = '0;
  logic [63:0] vec_data = '0;
  logic busy, done;
  mac_feeder_if #(.RW(RW), .CW(CW)) ifc ();
  mac_feeder dut (
    .clk(clk), .rst(rst), .vec_wr(vec_wr), .vec_addr(vec_addr), .vec_data(vec_data),
    .start(start), .m(ifc), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  beat_t sb[$];
  int eof_q[$];
  logic [63:0] xm [1024];
  bit pass_on = 0;
  int idle_at = 0;
  int n_cmp = 0;
  int n_bad = 0;
  beat_t mb;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (ifc.mac_wr) begin
      if (sb.size() == 0) chk("unexpected_mac_wr", ifc.mac_wr, 0);
      else begin
        mb = sb.pop_front();
        chk("wr_cycle", cyc, mb.due);
        chk("mac_row", ifc.mac_row, mb.row);
        chk("mac_v0", ifc.mac_v0, mb.v0);
        chk("mac_v1", ifc.mac_v1, mb.v1);
      end
    end
    if (ifc.mac_eof || done) begin
      chk("done_eq_eof", done, ifc.mac_eof);
      chk("eof_overlap_wr", ifc.mac_wr, 0);
      if (eof_q.size() == 0) chk("unexpected_eof", ifc.mac_eof | done, 0);
      else chk("eof_cycle", cyc, eof_q.pop_front());
    end
  end
  task automatic drive(input bit st, input bit vw, input logic [CW-1:0] va, input logic [63:0] vd,
                       input bit v, input logic [RW-1:0] r, input logic [CW-1:0] c,
                       input logic [63:0] val, input bit last, output bit acc);
    bit idle;
    beat_t b;
    @(negedge clk);
    chk("busy", busy, pass_on || cyc < idle_at);
    chk("in_ready", ifc.in_ready, pass_on);
    start = st; vec_wr = vw; vec_addr = va; vec_data = vd;
    ifc.in_valid = v; ifc.in_row = r; ifc.in_col = c; ifc.in_val = val; ifc.in_last = last;
    idle = !pass_on && cyc >= idle_at;
    acc = v && pass_on;
    if (acc) begin
      b.row = r; b.v0 = val; b.v1 = xm[c]; b.due = cyc + 2;
      sb.push_back(b);
      if (last) begin
        eof_q.push_back(cyc + 3);
        pass_on = 0;
        idle_at = cyc + 4;
      end
    end
    if (idle && vw) xm[va] = vd;
    if (idle && st) pass_on = 1;
  endtask
  task automatic idle_cyc();
    bit a;
    drive(0, 0, '0, '0, 0, '0, '0, '0, 0, a);
  endtask
  task automatic vwrite(input logic [CW-1:0] addr, input logic [63:0] data);
    bit a;
    drive(0, 1, addr, data, 0, '0, '0, '0, 0, a);
  endtask
  task automatic do_start();
    bit a;
    drive(1, 0, '0, '0, 0, '0, '0, '0, 0, a);
  endtask
  task automatic send(input logic [RW-1:0] r, input logic [CW-1:0] c, input logic [63:0] val, input bit last);
    bit a;
    int n = 0;
    do begin
      drive(0, 0, '0, '0, 1, r, c, val, last, a);
      n++;
    end while (!a && n < 20);
    if (!a) chk("accept_timeout", a, 1);
  endtask
  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || eof_q.size() != 0) && n < 50) begin
      idle_cyc();
      n++;
    end
    chk("drain_timeout", sb.size() + eof_q.size(), 0);
    repeat (2) idle_cyc();
  endtask
  initial begin
    bit a;
    ifc.in_valid = 0; ifc.in_row = '0; ifc.in_col = '0; ifc.in_val = '0; ifc.in_last = 0;
    repeat (100) begin
      @(negedge clk);
      chk("reset_outputs", {ifc.in_ready, ifc.mac_wr, ifc.mac_eof, busy}, 0);
    end
    rst = 0;
    for (int i = 0; i < 4; i++) vwrite(CW'(i), $realtobits(real'(i + 1)));
    for (int i = 4; i < 16; i++) vwrite(CW'(i), {$urandom, $urandom});
    // two back-to-back entries
    do_start();
    send(0, 2, $realtobits(0.5), 0);
    send(1, 0, $realtobits(1.5), 1);
    wait_drain();
    // 25 entries, valid every other cycle
    do_start();
    for (int i = 0; i < 25; i++) begin
      idle_cyc();
      send(RW'($urandom_range(1023)), CW'($urandom_range(15)), {$urandom, $urandom}, i == 24);
    end
    wait_drain();
    // vec_wr during RUN must not land
    do_start();
    vwrite(0, $realtobits(9.0));
    send(0, 0, $realtobits(2.5), 1);
    wait_drain();
    // start during RUN ignored, second start in IDLE runs a new pass
    do_start();
    do_start();
    send(3, 1, {$urandom, $urandom}, 1);
    wait_drain();
    do_start();
    send(4, 3, {$urandom, $urandom}, 0);
    send(5, 2, {$urandom, $urandom}, 1);
    wait_drain();
    // start and vec_wr together in IDLE
    drive(1, 1, 7, 64'h4022_0000_0000_0000, 0, '0, '0, '0, 0, a);
    send(6, 7, {$urandom, $urandom}, 1);
    wait_drain();
    // random valid pattern
    do_start();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1) == 1) idle_cyc();
      send(RW'($urandom_range(1023)), CW'($urandom_range(15)), {$urandom, $urandom}, i == 39);
    end
    wait_drain();
    // reset one cycle after an accept discards the entry
    do_start();
    send(9, 1, {$urandom, $urandom}, 0);
    @(negedge clk);
    rst = 1; ifc.in_valid = 0;
    while (sb.size() != 0 && sb[$].due > cyc) void'(sb.pop_back());
    while (eof_q.size() != 0 && eof_q[$] > cyc) void'(eof_q.pop_back());
    pass_on = 0; idle_at = 0;
    @(negedge clk);
    rst = 0;
    chk("post_reset_idle", {busy, ifc.in_ready}, 0);
    repeat (6) idle_cyc();
    chk("final_queues", sb.size() + eof_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
